// File: rtl/unified_mem_controller_pkg.sv
// Shared types and constants for the unified memory controller.
package unified_mem_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  localparam int I_BLOCK_BYTES = 16;
  localparam int D_BLOCK_BYTES = 4;
  localparam int BLK_IDX_W     = 6;

endpackage

// File: rtl/unified_mem_controller_mem_byte_array.sv
// Byte-addressed backing store: 16-byte combinational read port, 4-byte write port.
// Read data is valid in the same cycle; writes land on the rising edge. No reset.
module mem_byte_array
  import unified_mem_controller_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic                         clk,
  input  logic                         rd_en,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [8*I_BLOCK_BYTES-1:0]   rd_data,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [8*D_BLOCK_BYTES-1:0]   wr_data
);

  logic [7:0] mem_q [MEM_BYTES];

  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      for (int k = 0; k < I_BLOCK_BYTES; k++) begin
        rd_data[8*k +: 8] = mem_q[rd_addr + ADDR_W'(k)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < D_BLOCK_BYTES; k++) begin
        mem_q[wr_addr + ADDR_W'(k)] <= wr_data[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/unified_mem_controller.sv
// Round-robin responder serving I-cache (128b read) and D-cache (32b read/write) blocks from one array.
// Each grant holds the array MEM_LATENCY cycles; a loser's BUSYWAIT stays high until its own access completes.
module unified_mem_controller
  import unified_mem_controller_pkg::*;
#(
  parameter int MEM_LATENCY = 5,
  parameter int DATA_BASE   = 768,
  parameter int MEM_BYTES   = 1024
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         I_READ,
  input  logic [5:0]   I_ADDRESS,
  output logic [127:0] I_READDATA,
  output logic         I_BUSYWAIT,
  input  logic         D_READ,
  input  logic         D_WRITE,
  input  logic [5:0]   D_ADDRESS,
  input  logic [31:0]  D_WRITEDATA,
  output logic [31:0]  D_READDATA,
  output logic         D_BUSYWAIT
);

  localparam int ADDR_W = $clog2(MEM_BYTES);
  localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               i_done_q, i_done_d;
  logic               d_done_q, d_done_d;
  port_e              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               is_write_q, is_write_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [127:0]       i_rdata_q, i_rdata_d;
  logic [31:0]        d_rdata_q, d_rdata_d;

  logic               i_pend, d_pend, grant_i, grant_d, access;
  logic               arr_rd_en, arr_wr_en;
  logic [ADDR_W-1:0]  i_byte_addr, d_byte_addr;
  logic [127:0]       arr_rd_data;

  assign i_pend      = I_READ & ~i_done_q;
  assign d_pend      = (D_READ | D_WRITE) & ~d_done_q;
  assign I_BUSYWAIT  = i_pend;
  assign D_BUSYWAIT  = d_pend;
  assign I_READDATA  = i_rdata_q;
  assign D_READDATA  = d_rdata_q;

  assign i_byte_addr = ADDR_W'(I_ADDRESS) << 4;
  assign d_byte_addr = ADDR_W'(DATA_BASE) + (ADDR_W'(D_ADDRESS) << 2);

  // On a tie the port that did not win the previous tie gets the array.
  assign grant_d = (state_q == IDLE) & d_pend & (~i_pend | (last_grant_q == PORT_I));
  assign grant_i = (state_q == IDLE) & i_pend & ~grant_d;
  assign access  = (state_q != IDLE) & (cnt_q == '0);

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d)      state_d = SERVE_D;
        else if (grant_i) state_d = SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    is_write_d   = is_write_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    arr_rd_en    = 1'b0;
    arr_wr_en    = 1'b0;

    if (grant_d | grant_i) begin
      cnt_d      = CNT_LOAD;
      addr_d     = grant_d ? d_byte_addr : i_byte_addr;
      is_write_d = grant_d & D_WRITE;
      wdata_d    = D_WRITEDATA;
      if (i_pend & d_pend) last_grant_d = grant_d ? PORT_D : PORT_I;
    end else if ((state_q != IDLE) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    // A reset on the access edge must not leave a partial write behind.
    if (access) begin
      if (state_q == SERVE_I) begin
        i_done_d  = 1'b1;
        arr_rd_en = 1'b1;
        i_rdata_d = arr_rd_data;
      end else begin
        d_done_d = 1'b1;
        if (is_write_q) begin
          arr_wr_en = ~RESET;
        end else begin
          arr_rd_en = 1'b1;
          d_rdata_d = arr_rd_data[31:0];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q        <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      last_grant_q <= PORT_I;
      addr_q       <= '0;
      is_write_q   <= 1'b0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      cnt_q        <= cnt_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      is_write_q   <= is_write_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  mem_byte_array #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_array (
    .clk     (CLK),
    .rd_en   (arr_rd_en),
    .rd_addr (addr_q),
    .rd_data (arr_rd_data),
    .wr_en   (arr_wr_en),
    .wr_addr (addr_q),
    .wr_data (wdata_q)
  );

endmodule

// File: tb/tb_unified_mem_controller.sv
// Scenario bench for unified_mem_controller: expected read data is queued at request time and popped on completion.
module tb_unified_mem_controller;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         I_READ;
  logic [5:0]   I_ADDRESS;
  logic [127:0] I_READDATA;
  logic         I_BUSYWAIT;
  logic         D_READ;
  logic         D_WRITE;
  logic [5:0]   D_ADDRESS;
  logic [31:0]  D_WRITEDATA;
  logic [31:0]  D_READDATA;
  logic         D_BUSYWAIT;

  int checks = 0;
  int errors = 0;

  logic [31:0]  d_exp_q[$];
  logic [127:0] i_exp_q[$];

  unified_mem_controller dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Called at a falling edge with requests already driven. Counts busy cycles per port,
  // captures read data in the done cycle and drops the request there unless hold is set.
  task automatic run_ports(input bit hold, output int ci, output int cd,
                           output logic [127:0] idat, output logic [31:0] ddat);
    bit i_fin = 1'b0;
    bit d_fin = 1'b0;
    ci = 0; cd = 0; idat = '0; ddat = '0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (!i_fin) begin
        if (I_BUSYWAIT) ci++;
        else begin
          i_fin = 1'b1; idat = I_READDATA;
          if (!hold) I_READ = 1'b0;
        end
      end
      if (!d_fin) begin
        if (D_BUSYWAIT) cd++;
        else begin
          d_fin = 1'b1; ddat = D_READDATA;
          if (!hold) begin D_READ = 1'b0; D_WRITE = 1'b0; end
        end
      end
      if (i_fin && d_fin) break;
      @(negedge CLK);
    end
  endtask

  task automatic d_access(input bit wr, input logic [5:0] a, input logic [31:0] wd,
                          output int cyc, output logic [31:0] rd);
    int ci;
    logic [127:0] idat;
    @(negedge CLK);
    D_ADDRESS = a; D_WRITEDATA = wd;
    if (wr) D_WRITE = 1'b1; else D_READ = 1'b1;
    run_ports(1'b0, ci, cyc, idat, rd);
  endtask

  task automatic i_access(input logic [5:0] a, output int cyc, output logic [127:0] rd);
    int cd;
    logic [31:0] ddat;
    @(negedge CLK);
    I_ADDRESS = a; I_READ = 1'b1;
    run_ports(1'b0, cyc, cd, rd, ddat);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    I_READ = 0; D_READ = 0; D_WRITE = 0;
    I_ADDRESS = '0; D_ADDRESS = '0; D_WRITEDATA = '0;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    checks++; if (I_READDATA !== 128'h0) begin errors++; $display("FAIL reset_irdata got %h want 0", I_READDATA); end
    checks++; if (D_READDATA !== 32'h0) begin errors++; $display("FAIL reset_drdata got %h want 0", D_READDATA); end
    checks++; if (I_BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_ibusy got %b want 0", I_BUSYWAIT); end
    checks++; if (D_BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_dbusy got %b want 0", D_BUSYWAIT); end
    RESET = 1'b0;
  endtask

  task automatic test_d_read();
    int cyc;
    logic [31:0] rd;
    logic [31:0] exp;
    d_access(1'b1, 6'd0, 32'h44332211, cyc, rd);
    checks++; if (cyc != 6) begin errors++; $display("FAIL d_write0_cycles got %0d want 6", cyc); end
    d_exp_q.push_back(32'h44332211);
    d_access(1'b0, 6'd0, 32'h0, cyc, rd);
    exp = d_exp_q.pop_front();
    checks++; if (cyc != 6) begin errors++; $display("FAIL d_read_cycles got %0d want 6", cyc); end
    checks++; if (rd !== exp) begin errors++; $display("FAIL d_read_data got %h want %h", rd, exp); end
  endtask

  task automatic test_i_read();
    int cyc;
    logic [127:0] rd;
    logic [127:0] exp;
    // D blocks 4..7 alias instruction block 49 (bytes 784..799).
    for (int b = 0; b < 4; b++) begin
      logic [31:0] rdd;
      logic [31:0] w;
      w = {8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)};
      d_access(1'b1, 6'(4 + b), w, cyc, rdd);
      checks++; if (cyc != 6) begin errors++; $display("FAIL i_preload_cycles blk %0d got %0d want 6", 4 + b, cyc); end
    end
    i_exp_q.push_back(128'h0F0E0D0C_0B0A0908_07060504_03020100);
    i_access(6'd49, cyc, rd);
    exp = i_exp_q.pop_front();
    checks++; if (cyc != 6) begin errors++; $display("FAIL i_read_cycles got %0d want 6", cyc); end
    checks++; if (rd !== exp) begin errors++; $display("FAIL i_read_data got %h want %h", rd, exp); end
  endtask

  task automatic test_write_read();
    int cyc;
    logic [31:0] rd;
    logic [127:0] ird;
    logic [31:0] exp;
    d_access(1'b1, 6'd3, 32'hDEADBEEF, cyc, rd);
    checks++; if (cyc != 6) begin errors++; $display("FAIL wr3_cycles got %0d want 6", cyc); end
    d_exp_q.push_back(32'hDEADBEEF);
    d_access(1'b0, 6'd3, 32'h0, cyc, rd);
    exp = d_exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL rd3_data got %h want %h", rd, exp); end
    // Instruction block 48 covers bytes 768..783: D block 0 in the low word, D block 3 in the top word.
    i_access(6'd48, cyc, ird);
    checks++; if (ird[127:96] !== 32'hDEADBEEF) begin errors++; $display("FAIL bytes780_783 got %h want deadbeef", ird[127:96]); end
    checks++; if (ird[31:0] !== 32'h44332211) begin errors++; $display("FAIL bytes768_771 got %h want 44332211", ird[31:0]); end
  endtask

  task automatic test_contention();
    int ci, cd;
    logic [127:0] idat, iexp;
    logic [31:0]  ddat, dexp;
    do_reset();
    @(negedge CLK);
    I_ADDRESS = 6'd49; D_ADDRESS = 6'd0; I_READ = 1'b1; D_READ = 1'b1;
    i_exp_q.push_back(128'h0F0E0D0C_0B0A0908_07060504_03020100);
    d_exp_q.push_back(32'h44332211);
    run_ports(1'b0, ci, cd, idat, ddat);
    iexp = i_exp_q.pop_front(); dexp = d_exp_q.pop_front();
    checks++; if (cd != 6) begin errors++; $display("FAIL cont1_d_cycles got %0d want 6", cd); end
    checks++; if (ci != 12) begin errors++; $display("FAIL cont1_i_cycles got %0d want 12", ci); end
    checks++; if (idat !== iexp) begin errors++; $display("FAIL cont1_i_data got %h want %h", idat, iexp); end
    checks++; if (ddat !== dexp) begin errors++; $display("FAIL cont1_d_data got %h want %h", ddat, dexp); end
    @(negedge CLK);
    I_ADDRESS = 6'd48; D_ADDRESS = 6'd3; I_READ = 1'b1; D_READ = 1'b1;
    d_exp_q.push_back(32'hDEADBEEF);
    run_ports(1'b0, ci, cd, idat, ddat);
    dexp = d_exp_q.pop_front();
    checks++; if (ci != 6) begin errors++; $display("FAIL cont2_i_cycles got %0d want 6", ci); end
    checks++; if (cd != 12) begin errors++; $display("FAIL cont2_d_cycles got %0d want 12", cd); end
    checks++; if (ddat !== dexp) begin errors++; $display("FAIL cont2_d_data got %h want %h", ddat, dexp); end
  endtask

  task automatic test_reset_mid_write();
    int cyc;
    logic [31:0] rd, exp, bytes;
    @(negedge CLK);
    D_ADDRESS = 6'd5; D_WRITEDATA = 32'hCAFEBABE; D_WRITE = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if (D_BUSYWAIT !== 1'b1) begin errors++; $display("FAIL rst_pre_busy cyc %0d got %b want 1", n, D_BUSYWAIT); end
      if (n < 2) @(negedge CLK);
    end
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    checks++; if (I_READDATA !== 128'h0) begin errors++; $display("FAIL rst_mid_irdata got %h want 0", I_READDATA); end
    checks++; if (D_READDATA !== 32'h0) begin errors++; $display("FAIL rst_mid_drdata got %h want 0", D_READDATA); end
    cyc = 0;
    for (int n = 0; n < 40; n++) begin
      if (n == 5) begin
        bytes = {dut.u_array.mem_q[791], dut.u_array.mem_q[790], dut.u_array.mem_q[789], dut.u_array.mem_q[788]};
        checks++; if (bytes !== 32'h07060504) begin errors++; $display("FAIL rst_abandoned_bytes got %h want 07060504", bytes); end
      end
      if (!D_BUSYWAIT) break;
      cyc++;
      @(negedge CLK);
      #1;
    end
    D_WRITE = 1'b0;
    checks++; if (cyc != 6) begin errors++; $display("FAIL rst_retry_cycles got %0d want 6", cyc); end
    d_exp_q.push_back(32'hCAFEBABE);
    d_access(1'b0, 6'd5, 32'h0, cyc, rd);
    exp = d_exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL rst_retry_data got %h want %h", rd, exp); end
  endtask

  task automatic test_back_to_back();
    int ci, cd;
    logic [127:0] idat;
    logic [31:0] ddat, exp;
    @(negedge CLK);
    D_ADDRESS = 6'd0; D_READ = 1'b1;
    d_exp_q.push_back(32'h44332211);
    d_exp_q.push_back(32'h44332211);
    run_ports(1'b1, ci, cd, idat, ddat);
    exp = d_exp_q.pop_front();
    checks++; if (cd != 6) begin errors++; $display("FAIL b2b_first_cycles got %0d want 6", cd); end
    checks++; if (ddat !== exp) begin errors++; $display("FAIL b2b_first_data got %h want %h", ddat, exp); end
    @(negedge CLK);
    run_ports(1'b0, ci, cd, idat, ddat);
    exp = d_exp_q.pop_front();
    checks++; if (cd != 6) begin errors++; $display("FAIL b2b_second_cycles got %0d want 6", cd); end
    checks++; if (ddat !== exp) begin errors++; $display("FAIL b2b_second_data got %h want %h", ddat, exp); end
    checks++; if (d_exp_q.size() != 0 || i_exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d want 0", d_exp_q.size() + i_exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_d_read();
    test_i_read();
    test_write_read();
    test_contention();
    test_reset_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
